// File: rtl/thor2023_dcache_way_sel_if.sv
// thor2023_dcache_way_sel_if
// Interface bundle between the dcache memory state machine and the way
// selector: commit/ack strobes, the miss-allocation handshake and the
// selected-way outputs. The master modport drives the strobes and the slave
// modport is the way selector itself.

interface thor2023_dcache_way_sel_if #(
    parameter int WAYS = 4,
    parameter int SETS = 256
);
    localparam int WB = $clog2(WAYS);
    localparam int SB = $clog2(SETS);

    // committed access (ack & dce & acr)
    logic          acc_v_i;
    logic          acc_st_i;
    logic          acc_hit_i;
    logic [SB-1:0] acc_set_i;
    logic [WB-1:0] acc_way_i;

    // miss allocation request and fill commit
    logic            alloc_req_i;
    logic [SB-1:0]   alloc_set_i;
    logic [WAYS-1:0] valid_i;
    logic            wr_dc_i;
    logic            inv_all_i;

    // way selector results
    logic          alloc_rdy_o;
    logic          alloc_vld_o;
    logic [WB-1:0] alloc_way_o;
    logic [WB-1:0] wway_o;
    logic          busy_o;

    modport master (
        output acc_v_i, acc_st_i, acc_hit_i, acc_set_i, acc_way_i,
        output alloc_req_i, alloc_set_i, valid_i, wr_dc_i, inv_all_i,
        input  alloc_rdy_o, alloc_vld_o, alloc_way_o, wway_o, busy_o
    );

    modport slave (
        input  acc_v_i, acc_st_i, acc_hit_i, acc_set_i, acc_way_i,
        input  alloc_req_i, alloc_set_i, valid_i, wr_dc_i, inv_all_i,
        output alloc_rdy_o, alloc_vld_o, alloc_way_o, wway_o, busy_o
    );
endinterface

// File: rtl/thor2023_dcache_way_sel.sv
// thor2023_dcache_way_sel
// Data-cache way selector for Thor2023. Tracks the way written by committed
// stores and fills (wway_o) and picks a victim way for miss allocation:
// lowest-index invalid way first, otherwise tree pseudo-LRU or LFSR-random.
// A per-set clear sweep runs after reset and after invalidate-all; busy_o is
// high while it runs and allocation requests are refused.
//
// Build option: define THOR2023_DCACHE_PLRU_EN to build the tree-PLRU table
// and use it for full-set victims. Without it, full-set victims come from the
// low bits of the 16-bit LFSR and touches are no-ops; the sweep still runs so
// busy_o timing does not depend on the option.

module thor2023_dcache_way_sel #(
    parameter int WAYS = 4,
    parameter int SETS = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    thor2023_dcache_way_sel_if.slave  bus
);
    localparam int WB = $clog2(WAYS);
    localparam int SB = $clog2(SETS);

    // sweep controller states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [0:0]    state;
    logic [SB-1:0] sweep_cnt;
    logic          busy;

    logic [15:0]   lfsr;

    logic          alloc_fire;
    logic          st_hit;
    logic          any_hit;
    logic          any_invalid;
    logic [WB-1:0] inv_way;
    logic [WB-1:0] full_victim;
    logic [WB-1:0] victim;

    logic          alloc_vld_q;
    logic [WB-1:0] alloc_way_q;
    logic [WB-1:0] wway_q;

    assign busy       = (state == ST_SWEEP);
    assign alloc_fire = bus.alloc_req_i & ~busy;
    assign st_hit     = bus.acc_v_i & bus.acc_st_i & bus.acc_hit_i;
    assign any_hit    = bus.acc_v_i & bus.acc_hit_i;

    // Sweep controller: walk every set once after reset or invalidate-all;
    // an invalidate-all arriving mid-sweep restarts the walk from set 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
        end else if (state == ST_SWEEP) begin
            if (bus.inv_all_i) begin
                sweep_cnt <= '0;
            end else if (sweep_cnt == SB'(SETS - 1)) begin
                state <= ST_IDLE;
            end else begin
                sweep_cnt <= sweep_cnt + SB'(1);
            end
        end else if (bus.inv_all_i) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
        end
    end

    // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Invalid-first: find the lowest-index way whose tag valid bit is clear.
    always_comb begin
        any_invalid = 1'b0;
        inv_way     = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_i[i]) begin
                any_invalid = 1'b1;
                inv_way     = WB'(i);
            end
        end
    end

    assign victim = any_invalid ? inv_way : full_victim;

`ifdef THOR2023_DCACHE_PLRU_EN
    // Tree geometry: WAYS-1 node bits per set, heap ordered (children 2n+1, 2n+2).
    localparam int NB = WAYS - 1;
    localparam int NW = (NB > 1) ? $clog2(NB) : 1;

    logic [NB-1:0] plru_tab [SETS];
    logic [SB-1:0] alloc_set_q;

    logic          plru_we;
    logic [SB-1:0] plru_addr;
    logic [NB-1:0] plru_wdata;

    // Point every node on the path to way w away from w (0 = victim in lower half).
    function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] bits,
                                                 input logic [WB-1:0] w);
        logic [NB-1:0] nbits;
        logic [WB-1:0] wsh;
        logic [NW-1:0] node;
        logic          b;
        nbits = bits;
        wsh   = w;
        node  = '0;
        for (int l = 0; l < WB; l++) begin
            b           = wsh[WB-1];
            nbits[node] = ~b;
            node        = NW'(2 * int'(node) + 1 + int'(b));
            wsh         = wsh << 1;
        end
        return nbits;
    endfunction

    // Follow the node bits from the root down to a leaf.
    function automatic logic [WB-1:0] plru_victim(input logic [NB-1:0] bits);
        logic [WB-1:0] v;
        logic [NW-1:0] node;
        logic          b;
        v    = '0;
        node = '0;
        for (int l = 0; l < WB; l++) begin
            b    = bits[node];
            v    = (v << 1) | WB'(b);
            node = NW'(2 * int'(node) + 1 + int'(b));
        end
        return v;
    endfunction

    assign full_victim = plru_victim(plru_tab[bus.alloc_set_i]);

    // Single PLRU write port: sweep clear, then fill touch, then hit touch.
    always_comb begin
        plru_we    = 1'b0;
        plru_addr  = '0;
        plru_wdata = '0;
        if (busy) begin
            plru_we    = 1'b1;
            plru_addr  = sweep_cnt;
            plru_wdata = '0;
        end else if (bus.wr_dc_i && alloc_vld_q) begin
            plru_we    = 1'b1;
            plru_addr  = alloc_set_q;
            plru_wdata = plru_touch(plru_tab[alloc_set_q], alloc_way_q);
        end else if (any_hit) begin
            plru_we    = 1'b1;
            plru_addr  = bus.acc_set_i;
            plru_wdata = plru_touch(plru_tab[bus.acc_set_i], bus.acc_way_i);
        end
    end

    // PLRU table storage; cleared set by set by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (plru_we) begin
            plru_tab[plru_addr] <= plru_wdata;
        end
    end

    // Remember which set the outstanding allocation belongs to for the fill touch.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_set_q <= '0;
        end else if (alloc_fire) begin
            alloc_set_q <= bus.alloc_set_i;
        end
    end
`else
    logic plru_unused;

    assign full_victim = lfsr[WB-1:0];
    assign plru_unused = ^{bus.acc_set_i, bus.alloc_set_i, any_hit};
`endif

    // Allocation result and write-way registers; fill commit has priority for wway.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_vld_q <= 1'b0;
            alloc_way_q <= '0;
            wway_q      <= '0;
        end else begin
            if (alloc_fire) begin
                alloc_vld_q <= 1'b1;
                alloc_way_q <= victim;
            end else if (bus.wr_dc_i) begin
                alloc_vld_q <= 1'b0;
            end
            if (bus.wr_dc_i) begin
                wway_q <= alloc_way_q;
            end else if (st_hit) begin
                wway_q <= bus.acc_way_i;
            end
        end
    end

    assign bus.alloc_rdy_o = ~busy;
    assign bus.alloc_vld_o = alloc_vld_q;
    assign bus.alloc_way_o = alloc_way_q;
    assign bus.wway_o      = wway_q;
    assign bus.busy_o      = busy;

endmodule

// File: tb/tb_thor2023_dcache_way_sel.sv
// tb_thor2023_dcache_way_sel
// Directed bench for the dcache way selector (WAYS=4, SETS=8). Stimulus pushes
// expected allocation victims and write-way values into queues; a monitor pops
// them whenever the DUT accepts an allocation or sees a write-way strobe.
// Full-set victims depend on THOR2023_DCACHE_PLRU_EN: PLRU values are hand
// computed, otherwise the victim is the low bits of a reference LFSR.

module tb_thor2023_dcache_way_sel;
    localparam int WAYS = 4;
    localparam int SETS = 8;
    localparam int WB   = 2;
    localparam int SB   = 3;

`ifdef THOR2023_DCACHE_PLRU_EN
    localparam bit PLRU_ON = 1'b1;
`else
    localparam bit PLRU_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    thor2023_dcache_way_sel_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

    thor2023_dcache_way_sel #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int alloc_q[$];
    int wway_q[$];
    logic [15:0] lfsr_m;

    // Reference LFSR, taps 16,14,13,11, seed ACE1 on reset.
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    function automatic int expFull(input int plru_way);
        return PLRU_ON ? plru_way : int'(lfsr_m[WB-1:0]);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic acc_v, input logic acc_st, input logic acc_hit,
                                 input int acc_set, input int acc_way,
                                 input logic areq, input int aset, input logic [3:0] valid,
                                 input logic wr, input logic inv);
        bus.acc_v_i     = acc_v;
        bus.acc_st_i    = acc_st;
        bus.acc_hit_i   = acc_hit;
        bus.acc_set_i   = SB'(acc_set);
        bus.acc_way_i   = WB'(acc_way);
        bus.alloc_req_i = areq;
        bus.alloc_set_i = SB'(aset);
        bus.valid_i     = valid;
        bus.wr_dc_i     = wr;
        bus.inv_all_i   = inv;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic hitCycle(input int set, input int way, input logic st);
        applyStimulus(1'b1, st, 1'b1, set, way, 1'b0, 0, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic allocCycle(input int set, input logic [3:0] valid);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, set, valid, 1'b0, 1'b0);
    endtask

    task automatic wrCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 4'hF, 1'b1, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wway"},      int'(bus.wway_o), 0);
        checkOutput({tag, "_alloc_way"}, int'(bus.alloc_way_o), 0);
        checkOutput({tag, "_alloc_vld"}, int'(bus.alloc_vld_o), 0);
        checkOutput({tag, "_busy"},      int'(bus.busy_o), 1);
        checkOutput({tag, "_rdy"},       int'(bus.alloc_rdy_o), 0);
    endtask

    // Monitor: sample the handshake mid-cycle, compare results after the edge.
    initial begin
        logic fa;
        logic fw;
        int   e;
        forever begin
            @(negedge clk);
            fa = !rst && bus.alloc_req_i && bus.alloc_rdy_o;
            fw = !rst && (bus.wr_dc_i || (bus.acc_v_i && bus.acc_st_i && bus.acc_hit_i));
            @(posedge clk);
            #2;
            if (fa) begin
                if (alloc_q.size() == 0) begin
                    checkOutput("alloc_accepted_unexpected", int'(fa), 0);
                end else begin
                    e = alloc_q.pop_front();
                    checkOutput("alloc_vld", int'(bus.alloc_vld_o), 1);
                    checkOutput("alloc_way", int'(bus.alloc_way_o), e);
                end
            end
            if (fw) begin
                if (wway_q.size() == 0) begin
                    checkOutput("wway_update_unexpected", int'(fw), 0);
                end else begin
                    e = wway_q.pop_front();
                    checkOutput("wway", int'(bus.wway_o), e);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus.
    initial begin
        int last;
        bus.acc_v_i = 1'b0; bus.acc_st_i = 1'b0; bus.acc_hit_i = 1'b0;
        bus.acc_set_i = '0; bus.acc_way_i = '0; bus.alloc_req_i = 1'b0;
        bus.alloc_set_i = '0; bus.valid_i = 4'hF; bus.wr_dc_i = 1'b0; bus.inv_all_i = 1'b0;

        rst = 1'b1;
        idleCycle();
        idleCycle();
        checkResetValues("reset");
        rst = 1'b0;

        // Sweep after reset: busy for exactly SETS cycles, requests refused.
        for (int i = 0; i < SETS; i++) begin
            checkOutput("sweep_busy", int'(bus.busy_o), 1);
            allocCycle(0, 4'b0000);
        end
        checkOutput("sweep_done_busy", int'(bus.busy_o), 0);
        checkOutput("sweep_done_rdy", int'(bus.alloc_rdy_o), 1);
        checkOutput("sweep_done_vld", int'(bus.alloc_vld_o), 0);

        // Store hit loads wway, load hit leaves it.
        wway_q.push_back(2);
        hitCycle(3, 2, 1'b1);
        hitCycle(3, 1, 1'b0);
        checkOutput("wway_after_load_hit", int'(bus.wway_o), 2);

        // PLRU on full set 5.
        hitCycle(5, 0, 1'b0);
        hitCycle(5, 1, 1'b0);
        hitCycle(5, 2, 1'b0);
        hitCycle(5, 3, 1'b0);
        alloc_q.push_back(expFull(0));
        allocCycle(5, 4'b1111);
        hitCycle(5, 0, 1'b0);
        alloc_q.push_back(expFull(2));
        allocCycle(5, 4'b1111);

        // Invalid-first.
        alloc_q.push_back(2);
        allocCycle(1, 4'b1011);
        alloc_q.push_back(0);
        allocCycle(1, 4'b0000);

        // Fill commit and store hit in the same cycle.
        alloc_q.push_back(3);
        allocCycle(6, 4'b0111);
        wway_q.push_back(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 6, 1, 1'b0, 0, 4'hF, 1'b1, 1'b0);
        checkOutput("vld_after_wr_dc", int'(bus.alloc_vld_o), 0);
        checkOutput("way_held_after_wr_dc", int'(bus.alloc_way_o), 3);
        last = expFull(0);
        alloc_q.push_back(last);
        allocCycle(6, 4'b1111);

        // Fill with and without an outstanding allocation.
        wway_q.push_back(last);
        wrCycle();
        wway_q.push_back(1);
        hitCycle(2, 1, 1'b1);
        wway_q.push_back(last);
        wrCycle();
        checkOutput("vld_after_idle_wr_dc", int'(bus.alloc_vld_o), 0);

        // New request in the same cycle as a fill commit.
        alloc_q.push_back(0);
        wway_q.push_back(last);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 2, 4'b1110, 1'b1, 1'b0);
        checkOutput("vld_alloc_with_wr_dc", int'(bus.alloc_vld_o), 1);

        // Invalidate-all, restarted at counter 4.
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 4'hF, 1'b0, 1'b1);
        checkOutput("inv_busy", int'(bus.busy_o), 1);
        for (int i = 0; i < 4; i++) begin
            idleCycle();
            checkOutput("inv_sweep_busy", int'(bus.busy_o), 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 5, 4'b1111, 1'b0, 1'b1);
        checkOutput("inv_restart_busy", int'(bus.busy_o), 1);
        checkOutput("inv_restart_rdy", int'(bus.alloc_rdy_o), 0);
        for (int i = 0; i < 7; i++) begin
            allocCycle(5, 4'b1111);
            checkOutput("inv_restart_sweep_busy", int'(bus.busy_o), 1);
        end
        allocCycle(5, 4'b1111);
        checkOutput("inv_done_busy", int'(bus.busy_o), 0);
        checkOutput("inv_done_rdy", int'(bus.alloc_rdy_o), 1);
        alloc_q.push_back(expFull(0));
        allocCycle(5, 4'b1111);

        // Reset in the middle of an allocation.
        alloc_q.push_back(1);
        allocCycle(4, 4'b1101);
        rst = 1'b1;
        idleCycle();
        checkResetValues("midrst");
        rst = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            checkOutput("midrst_sweep_busy", int'(bus.busy_o), 1);
            idleCycle();
        end
        checkOutput("midrst_done_busy", int'(bus.busy_o), 0);

        idleCycle();
        idleCycle();
        checkOutput("alloc_queue_drained", alloc_q.size(), 0);
        checkOutput("wway_queue_drained", wway_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/thor2023_dcache_way_sel.md
# thor2023_dcache_way_sel

Parametrised data-cache way selector for Thor2023. It records which way a committed store hit, so the data-array write enables the correct way. It chooses a victim way for miss fills, preferring invalid ways and then using tree pseudo-LRU or LFSR-random replacement. It sits beside the dcache tag array and is driven by the memory state machine's ack/commit strobes.

## Interface
- WAYS, 4, associativity; power of two, 2..8; WB = $clog2(WAYS)
- SETS, 256, sets per way; power of two, 2..1024; SB = $clog2(SETS)
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- acc_v_i  in  1  cacheable access committed this cycle (ack & dce & acr permits)
- acc_st_i  in  1  committed access is a store (MR_STORE/MR_MOVST)
- acc_hit_i  in  1  committed access hit in tags
- acc_set_i  in  SB  set index of access
- acc_way_i  in  WB  way that hit
- alloc_req_i  in  1  miss: request victim for alloc_set_i
- alloc_set_i  in  SB  set index of miss
- valid_i  in  WAYS  tag valid bits of alloc_set_i, sampled with alloc_req_i
- wr_dc_i  in  1  fill data written to cache; commits the allocation
- inv_all_i  in  1  invalidate-all pulse; clears replacement state
- alloc_rdy_o  out  1  alloc_req_i will be accepted (= !busy_o)
- alloc_vld_o  out  1  alloc_way_o holds a victim
- alloc_way_o  out  WB  chosen victim way
- wway_o  out  WB  way for data-array writes
- busy_o  out  1  replacement-state clear sweep in progress

## Operation
- PLRU state: SETS x (WAYS-1) bits, heap-ordered tree.
  - Node 0 is the root. Children of node n are 2n+1 and 2n+2.
  - Bit 0 means the victim is in the lower half.
- Touch(set, w): every node on the path to w is written to point away from w.
- Victim: walk the tree from the root following the bits.
- Invalid-first: if any valid_i bit is 0, the victim is the lowest-index invalid way, regardless of mode.
- Store hit: acc_v_i & acc_st_i & acc_hit_i -> wway_o <= acc_way_i.
- Any hit: acc_v_i & acc_hit_i -> Touch(acc_set_i, acc_way_i).
- Alloc, accepted only when alloc_rdy_o:
  - the set is latched;
  - alloc_way_o is computed from the pre-update state;
  - alloc_vld_o is set.
- wr_dc_i:
  - wway_o <= alloc_way_o;
  - Touch(latched set, alloc_way_o);
  - alloc_vld_o <= 0.
  - alloc_way_o stays unchanged until the next accepted request.
- wr_dc_i with alloc_vld_o=0: wway_o <= alloc_way_o; no Touch.
- Simultaneous events:
  - The PLRU table has one write port; a wr_dc_i Touch wins and the same-cycle hit Touch is dropped.
  - The wway_o load priority is wr_dc_i, then store hit.
  - A new alloc_req_i in the same cycle as wr_dc_i is accepted; alloc_vld_o ends the cycle at 1.
- Sweep:
  - Started by rst, or by inv_all_i when not busy.
  - A counter walks sets 0..SETS-1, clearing one set per cycle; busy_o=1 throughout.
  - While busy: alloc requests are refused, hit Touches are ignored, wway_o updates still occur.
  - inv_all_i during a sweep restarts the counter at 0.

## Timing
- Reset values:
  - wway_o=0, alloc_way_o=0, alloc_vld_o=0;
  - busy_o=1, alloc_rdy_o=0;
  - LFSR=16'hACE1.
- The sweep after rst takes exactly SETS cycles; busy_o falls in cycle SETS after rst deasserts.
- rst asserted mid-sweep or mid-allocation restarts everything to the reset values.
- Alloc latency: request accepted at edge N -> alloc_vld_o/alloc_way_o valid after edge N (one cycle).
- wway_o latency: one cycle after the qualifying strobe.
- Touch is visible to an alloc request issued in the following cycle; a same-cycle request sees the old state.
- The LFSR advances every cycle, including while busy.

## Configuration
- THOR2023_DCACHE_PLRU_EN defined:
  - the tree-PLRU table and Touch logic are built;
  - the victim of a full set is the PLRU way.
- THOR2023_DCACHE_PLRU_EN undefined:
  - no PLRU table is built; Touch is a no-op;
  - the victim of a full set is LFSR[WB-1:0];
  - the sweep still runs, so busy_o timing is identical.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.

## Test plan
- Reset, WAYS=4, SETS=8: busy_o=1 for 8 cycles, then 0; all outputs at their reset values.
- Store hit set 3 way 2 -> next cycle wway_o=2. Load hit way 1 -> wway_o unchanged.
- PLRU, set 5 full: touch ways 0,1,2,3 in that order, then alloc_req -> alloc_way_o=0. Touch 0, alloc -> 2.
- valid_i=4'b1011, set full otherwise -> alloc_way_o=2. With valid_i=4'b0000 -> 0.
- Same-cycle wr_dc_i (alloc way 3) and store hit way 1 -> wway_o=3; the PLRU records way 3 only.
- inv_all_i mid-sweep at counter 4 -> sweep restarts; alloc_req_i refused for 8 further cycles.
